// File: rtl/pe_proto_pkg.sv
// PE B-protocol definitions shared by the column feeder: control codes,
// feeder state encoding and word-building helpers.
package pe_proto_pkg;

  // Canonical B-word geometry; feeder parameters NB/NID must match these.
  localparam int PE_NB  = 27;
  localparam int PE_NID = 7;

  // Control codes carried twice in bits [5:3] and [2:0] of a control word.
  localparam logic [2:0] C_RSET = 3'd1;
  localparam logic [2:0] C_ALT2 = 3'd2;
  localparam logic [2:0] C_INTM = 3'd3;
  localparam logic [2:0] C_LOAD = 3'd4;
  localparam logic [2:0] C_MULT = 3'd5;

  // One-hot feeder states; each names the word currently on b_out.
  typedef enum logic [8:0] {
    ST_IDLE  = 9'b000000001,
    ST_RST   = 9'b000000010,
    ST_MODE  = 9'b000000100,
    ST_LOAD  = 9'b000001000,
    ST_WGT   = 9'b000010000,
    ST_MULT  = 9'b000100000,
    ST_BIAS  = 9'b001000000,
    ST_FIN   = 9'b010000000,
    ST_DRAIN = 9'b100000000
  } feeder_state_t;

  function automatic logic [PE_NB-1:0] ctrl_word(input logic [2:0] c);
    logic [PE_NB-1:0] w;
    w          = '0;
    w[PE_NB-1] = 1'b1;
    w[5:0]     = {c, c};
    return w;
  endfunction

  function automatic logic [PE_NB-1:0] weight_word(input logic [PE_NID-1:0] idx,
                                                   input logic [5:0]        wt);
    logic [PE_NB-1:0] w;
    w               = '0;
    w[PE_NB-1]      = 1'b1;
    w[PE_NID+5:6]   = idx;
    w[5:0]          = wt;
    return w;
  endfunction

  function automatic logic [PE_NB-1:0] bias_word(input logic [PE_NB-2:0] b);
    return {1'b0, b};
  endfunction

  // Equal halves mean a zero product and would be mistaken for a control word.
  function automatic logic is_zero_weight(input logic [5:0] wt);
    return wt[5:3] == wt[2:0];
  endfunction

endpackage

// File: rtl/pe_feeder_wbuf.sv
// Per-row weight register file for the column feeder: one write port,
// one combinational read port. Writes to rows >= ROWS are dropped.
module pe_feeder_wbuf #(
  parameter int NID  = 7,
  parameter int ROWS = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           we,
  input  logic [NID-1:0] waddr,
  input  logic [5:0]     wdata,
  input  logic [NID-1:0] raddr,
  output logic [5:0]     rdata
);

  logic [5:0] mem_reg [ROWS];

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    // Each row captures the write data when addressed.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        mem_reg[gi] <= '0;
      else if (we && waddr == NID'(gi))
        mem_reg[gi] <= wdata;
    end
  end

  // Read mux; out-of-range rows read as zero.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < ROWS; i++)
      if (raddr == NID'(i))
        rdata = mem_reg[i];
  end

endmodule

// File: rtl/pe_column_feeder.sv
// Top-of-column B-stream transmitter for one systolic PE column.
// Per job: RSET, mode, LOAD, per-row weights (descending), MULT, bias stream,
// ALT2 with done. Optional macro PE_COLUMN_FEEDER_DRAIN_EN appends ROWS idle
// words after ALT2 and moves done to the last of them.
module pe_column_feeder
  import pe_proto_pkg::*;
#(
  parameter int NB   = PE_NB,
  parameter int NID  = PE_NID,
  parameter int ROWS = 8,
  parameter int VW   = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wt_we,
  input  logic [NID-1:0] wt_addr,
  input  logic [5:0]    wt_data,
  input  logic          start,
  input  logic          int_mode,
  input  logic [VW-1:0] nvec,
  input  logic          bias_valid,
  input  logic [NB-2:0] bias_data,
  output logic          bias_ready,
  output logic [NB-1:0] b_out,
  output logic          act_en,
  output logic          busy,
  output logic          done,
  output logic          underrun
);

  localparam logic [NID-1:0] LAST_ROW = NID'(ROWS - 1);

  feeder_state_t  state_reg;
  logic [NB-1:0]  b_out_reg;
  logic           act_en_reg;
  logic           busy_reg;
  logic           done_reg;
  logic           underrun_reg;
  logic           int_mode_reg;
  logic [NID-1:0] row_cnt_reg;
  logic [VW-1:0]  vcnt_reg;

  logic           buf_we;
  logic [NID-1:0] rd_addr;
  logic [5:0]     rd_w;

  // Weight writes only land while idle and not in the cycle a job starts.
  assign buf_we = wt_we && (state_reg == ST_IDLE) && !start;

  // LOAD fetches the top row; WGT fetches the row below the one on b_out.
  assign rd_addr = (state_reg == ST_LOAD) ? row_cnt_reg : row_cnt_reg - 1'b1;

  pe_feeder_wbuf #(.NID(NID), .ROWS(ROWS)) u_wbuf (
    .clk   (clk),
    .rst   (rst),
    .we    (buf_we),
    .waddr (wt_addr),
    .wdata (wt_data),
    .raddr (rd_addr),
    .rdata (rd_w)
  );

  // A bias word is taken on any edge that moves into (or stays in) BIAS.
  assign bias_ready = ((state_reg == ST_MULT) || (state_reg == ST_BIAS)) && (vcnt_reg != '0);

  assign b_out    = b_out_reg;
  assign act_en   = act_en_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;
  assign underrun = underrun_reg;

  // Job sequencer: picks the next state and registers the word it emits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      b_out_reg    <= '0;
      act_en_reg   <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      underrun_reg <= 1'b0;
      int_mode_reg <= 1'b0;
      row_cnt_reg  <= '0;
      vcnt_reg     <= '0;
    end else begin
      b_out_reg  <= '0;
      act_en_reg <= 1'b0;
      done_reg   <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          busy_reg <= 1'b0;
          if (start) begin
            state_reg    <= ST_RST;
            b_out_reg    <= ctrl_word(C_RSET);
            busy_reg     <= 1'b1;
            underrun_reg <= 1'b0;
            int_mode_reg <= int_mode;
            vcnt_reg     <= nvec;
          end
        end
        ST_RST: begin
          state_reg <= ST_MODE;
          b_out_reg <= ctrl_word(int_mode_reg ? C_INTM : C_ALT2);
        end
        ST_MODE: begin
          state_reg   <= ST_LOAD;
          b_out_reg   <= ctrl_word(C_LOAD);
          row_cnt_reg <= LAST_ROW;
        end
        ST_LOAD, ST_WGT: begin
          if (state_reg == ST_WGT && row_cnt_reg == '0) begin
            state_reg <= ST_MULT;
            b_out_reg <= ctrl_word(C_MULT);
          end else begin
            state_reg <= ST_WGT;
            if (state_reg == ST_WGT)
              row_cnt_reg <= row_cnt_reg - 1'b1;
            // Zero weights go out as gaps so the row stays transparent.
            b_out_reg <= is_zero_weight(rd_w) ? '0 : weight_word(rd_addr, rd_w);
          end
        end
        ST_MULT, ST_BIAS: begin
          if (vcnt_reg == '0) begin
            state_reg <= ST_FIN;
            b_out_reg <= ctrl_word(C_ALT2);
`ifndef PE_COLUMN_FEEDER_DRAIN_EN
            done_reg  <= 1'b1;
`endif
          end else begin
            state_reg  <= ST_BIAS;
            vcnt_reg   <= vcnt_reg - 1'b1;
            act_en_reg <= 1'b1;
            // The array cannot stall: a missing bias becomes 0 and is flagged.
            b_out_reg  <= bias_word(bias_valid ? bias_data : '0);
            if (!bias_valid)
              underrun_reg <= 1'b1;
          end
        end
        ST_FIN: begin
`ifdef PE_COLUMN_FEEDER_DRAIN_EN
          state_reg   <= ST_DRAIN;
          row_cnt_reg <= LAST_ROW;
          done_reg    <= (LAST_ROW == '0);
`else
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
`endif
        end
        ST_DRAIN: begin
`ifdef PE_COLUMN_FEEDER_DRAIN_EN
          if (row_cnt_reg == '0) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end else begin
            row_cnt_reg <= row_cnt_reg - 1'b1;
            done_reg    <= (row_cnt_reg == NID'(1));
          end
`else
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
`endif
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pe_column_feeder.sv
// Self-checking bench for pe_column_feeder (ROWS=4): a job-level model
// builds the expected per-cycle output stream, a compare process checks it.
module tb_pe_column_feeder;

  localparam int NB   = 27;
  localparam int NID  = 7;
  localparam int ROWS = 4;
  localparam int VW   = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           wt_we;
  logic [NID-1:0] wt_addr;
  logic [5:0]     wt_data;
  logic           start;
  logic           int_mode;
  logic [VW-1:0]  nvec;
  logic           bias_valid;
  logic [NB-2:0]  bias_data;
  logic           bias_ready;
  logic [NB-1:0]  b_out;
  logic           act_en;
  logic           busy;
  logic           done;
  logic           underrun;

  always #5 clk = ~clk;

  pe_column_feeder #(.NB(NB), .NID(NID), .ROWS(ROWS), .VW(VW)) dut (
    .clk        (clk),
    .rst        (rst),
    .wt_we      (wt_we),
    .wt_addr    (wt_addr),
    .wt_data    (wt_data),
    .start      (start),
    .int_mode   (int_mode),
    .nvec       (nvec),
    .bias_valid (bias_valid),
    .bias_data  (bias_data),
    .bias_ready (bias_ready),
    .b_out      (b_out),
    .act_en     (act_en),
    .busy       (busy),
    .done       (done),
    .underrun   (underrun)
  );

  typedef struct {
    logic [NB-1:0] b;
    logic          act;
    logic          dn;
    logic          bsy;
    logic          rdy;
  } exp_t;

  exp_t exp_q[$];
  exp_t build_q[$];
  exp_t cur;

  int vectors    = 0;
  int miscompares = 0;

  logic [5:0]    wts    [ROWS];
  logic          bias_v [8];
  logic [NB-2:0] bias_d [8];

  task automatic chk(input string nm, input logic [NB-1:0] got, input logic [NB-1:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, got, want, $time);
    end
  endtask

  // Model word builders, straight from the word-format rules.
  function automatic logic [NB-1:0] m_ctrl(input int c);
    return (NB'(1) << (NB - 1)) | NB'(c * 9);
  endfunction

  function automatic logic [NB-1:0] m_wgt(input int r, input logic [5:0] w);
    if (w[5:3] == w[2:0]) return '0;
    return (NB'(1) << (NB - 1)) | (NB'(r) << 6) | NB'(w);
  endfunction

  task automatic add(input logic [NB-1:0] b, input logic act, input logic dn, input logic bsy);
    exp_t e;
    e.b = b; e.act = act; e.dn = dn; e.bsy = bsy; e.rdy = 1'b0;
    build_q.push_back(e);
  endtask

  // Expected outputs for cycles S+1, S+2, ... of one job, plus two idle cycles.
  task automatic model_job(input logic im, input int nv);
    build_q.delete();
    add(m_ctrl(1), 0, 0, 1);
    add(m_ctrl(im ? 3 : 2), 0, 0, 1);
    add(m_ctrl(4), 0, 0, 1);
    for (int r = ROWS - 1; r >= 0; r--) add(m_wgt(r, wts[r]), 0, 0, 1);
    add(m_ctrl(5), 0, 0, 1);
    for (int i = 0; i < nv; i++) add(bias_v[i] ? {1'b0, bias_d[i]} : '0, 1, 0, 1);
`ifdef PE_COLUMN_FEEDER_DRAIN_EN
    add(m_ctrl(2), 0, 0, 1);
    for (int i = 0; i < ROWS; i++) add('0, 0, (i == ROWS - 1), 1);
`else
    add(m_ctrl(2), 0, 1, 1);
`endif
    add('0, 0, 0, 0);
    add('0, 0, 0, 0);
    // bias_ready is up in the cycle before each bias word appears.
    for (int i = 0; i + 1 < build_q.size(); i++) build_q[i].rdy = build_q[i + 1].act;
  endtask

  // Compare process: one expected entry per cycle while a job is in flight.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      $display("cyc b_out=0x%07h act_en=%0d done=%0d busy=%0d rdy=%0d exp_b=0x%07h",
               b_out, act_en, done, busy, bias_ready, cur.b);
      chk("b_out", b_out, cur.b);
      chk("act_en", NB'(act_en), NB'(cur.act));
      chk("done", NB'(done), NB'(cur.dn));
      chk("busy", NB'(busy), NB'(cur.bsy));
      chk("bias_ready", NB'(bias_ready), NB'(cur.rdy));
    end
  end

  task automatic write_w(input int r, input logic [5:0] w);
    @(negedge clk);
    wt_we = 1'b1; wt_addr = NID'(r); wt_data = w;
    @(negedge clk);
    wt_we = 1'b0;
  endtask

  task automatic run_job(input logic im, input int nv, input bit inject, input int abort_at);
    int  bidx;
    bit  rdy_seen;
    int  n;
    model_job(im, nv);
    n = build_q.size();
    @(negedge clk);
    start = 1'b1; int_mode = im; nvec = VW'(nv); bias_valid = 1'b0;
    foreach (build_q[i]) exp_q.push_back(build_q[i]);
    bidx = 0; rdy_seen = 1'b0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      start    = inject && (k == 5);
      int_mode = ~im;
      nvec     = '1;
      wt_we    = inject && (k == 6);
      wt_addr  = NID'(1);
      wt_data  = 6'o25;
      if (rdy_seen) bidx++;
      bias_valid = (bidx < nv) ? bias_v[bidx] : 1'b0;
      bias_data  = (bidx < nv) ? bias_d[bidx] : '0;
      rdy_seen   = bias_ready;
      if (k == 1) chk("underrun_clr", NB'(underrun), '0);
      if (k == abort_at) begin
        rst = 1'b1;
        #1;
        exp_q.delete();
        $display("rst mid-job: b_out=0x%07h busy=%0d done=%0d", b_out, busy, done);
        chk("rst_b_out", b_out, '0);
        chk("rst_busy", NB'(busy), '0);
        chk("rst_done", NB'(done), '0);
        chk("rst_act_en", NB'(act_en), '0);
        @(negedge clk);
        rst = 1'b0; start = 1'b0; wt_we = 1'b0; bias_valid = 1'b0;
        return;
      end
    end
    start = 1'b0; wt_we = 1'b0; bias_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wt_we = 1'b0; wt_addr = '0; wt_data = '0; start = 1'b0;
    int_mode = 1'b0; nvec = '0; bias_valid = 1'b0; bias_data = '0;
    repeat (2) @(negedge clk);
    chk("reset_b_out", b_out, '0);
    chk("reset_busy", NB'(busy), '0);
    chk("reset_done", NB'(done), '0);
    chk("reset_act_en", NB'(act_en), '0);
    chk("reset_underrun", NB'(underrun), '0);
    rst = 1'b0;

    wts[0] = 6'o12; wts[1] = 6'o00; wts[2] = 6'o31; wts[3] = 6'o03;
    for (int r = 0; r < ROWS; r++) write_w(r, wts[r]);
    write_w(5, 6'o77);  // out of range, must be dropped

    bias_v[0] = 1'b1; bias_d[0] = 26'd5;
    bias_v[1] = 1'b1; bias_d[1] = 26'd9;
    bias_v[2] = 1'b1; bias_d[2] = 26'd0;

    // Pin the model against hand-computed words of the first scenario.
    model_job(1'b1, 2);
    chk("pin_rset", build_q[0].b, 27'h4000009);
    chk("pin_intm", build_q[1].b, 27'h400001B);
    chk("pin_load", build_q[2].b, 27'h4000024);
    chk("pin_row3", build_q[3].b, 27'h40000C3);
    chk("pin_row2", build_q[4].b, 27'h4000099);
    chk("pin_gap1", build_q[5].b, 27'h0000000);
    chk("pin_row0", build_q[6].b, 27'h400000A);
    chk("pin_mult", build_q[7].b, 27'h400002D);
    chk("pin_bias0", build_q[8].b, 27'h0000005);
    chk("pin_bias1", build_q[9].b, 27'h0000009);
    chk("pin_alt2", build_q[10].b, 27'h4000012);
`ifdef PE_COLUMN_FEEDER_DRAIN_EN
    chk("pin_drain_done", NB'(build_q[14].dn), NB'(1));
    chk("pin_drain_busy", NB'(build_q[15].bsy), NB'(0));
`else
    chk("pin_done", NB'(build_q[10].dn), NB'(1));
    chk("pin_idle_busy", NB'(build_q[11].bsy), NB'(0));
`endif

    $display("job 1: int_mode=1 nvec=2 bias 5,9");
    run_job(1'b1, 2, 1'b0, 0);
    chk("underrun_job1", NB'(underrun), '0);

    $display("job 2: int_mode=0 nvec=0");
    run_job(1'b0, 0, 1'b0, 0);

    $display("job 3: second bias missing");
    bias_v[1] = 1'b0;
    run_job(1'b1, 2, 1'b0, 0);
    chk("underrun_set", NB'(underrun), NB'(1));
    repeat (3) @(negedge clk);
    chk("underrun_held", NB'(underrun), NB'(1));

    $display("job 4: start and wt_we while busy");
    bias_v[1] = 1'b1;
    run_job(1'b1, 2, 1'b1, 0);

    $display("job 5: repeat, weights unchanged");
    run_job(1'b1, 2, 1'b0, 0);

    $display("job 6: rst at S+6");
    run_job(1'b1, 2, 1'b0, 6);
    chk("post_rst_busy", NB'(busy), '0);

    $display("job 7: full sequence after rst");
    wts[0] = '0; wts[1] = '0; wts[2] = '0; wts[3] = '0;  // rst cleared the buffer
    run_job(1'b1, 2, 1'b0, 0);

    $display("job 8: new weights, nvec=3, uint");
    wts[0] = 6'o07; wts[1] = 6'o44; wts[2] = 6'o70; wts[3] = 6'o16;
    for (int r = 0; r < ROWS; r++) write_w(r, wts[r]);
    bias_v[0] = 1'b1; bias_d[0] = 26'd7;
    bias_v[1] = 1'b1; bias_d[1] = 26'h3FFFFFF;
    bias_v[2] = 1'b1; bias_d[2] = 26'd1;
    run_job(1'b0, 3, 1'b0, 0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global time bound so the bench always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
